// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction/data RAM preload engines:
// loader FSM encoding and the byte-lane ordering helper.
package imem_stream_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  // Maps the n-th emitted byte of a word to its lane index inside the word.
  function automatic int lane_sel(input int idx, input int nb, input bit big_endian);
    return big_endian ? (nb - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one stream word and presents its bytes one per cycle in the
// configured endian order; the lane counter parks on the last lane.
module imem_byte_serializer
  import imem_stream_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              adv,
  output logic [7:0]        byte_out,
  output logic              last_lane
);

  localparam int NB = WORD_W / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LW-1:0] LAST = LW'(NB - 1);

  logic [WORD_W-1:0] word_q;
  logic [LW-1:0]     lane;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      lane   <= '0;
    end else if (load) begin
      word_q <= word;
      lane   <= '0;
    end else if (adv && (lane != LAST)) begin
      lane <= lane + 1'b1;
    end
  end

  assign last_lane = (lane == LAST);
  assign byte_out  = word_q[lane_sel(int'(lane), NB, BIG_ENDIAN)*8 +: 8];

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction RAM preload engine: stream words in, RAM bytes out, CPU held in
// reset until the whole image is written without overflowing the RAM.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ACCEPT | in_ready high, waiting for a stream word
// WRITE  | emitting the latched word one byte per cycle
// DONE   | image complete, CPU released
// ERR    | image ran past DEPTH, CPU kept in reset
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_ovf,
  output logic [CNT_W-1:0]  word_count
);

  // Pointer is one bit wider so "one past the end" is representable.
  localparam int                 DEPTH_I = DEPTH;
  localparam logic [ADDR_W:0]    DEPTH_L = DEPTH_I[ADDR_W:0];

  logic [2:0]        state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_nxt;
  logic              last_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [7:0]        data_hold;
  logic [7:0]        ser_byte;
  logic              ser_last;
  logic              hs;
  logic              writing;
  logic              nxt_ovf;

  assign hs      = (state == S_ACCEPT) && in_valid;
  assign writing = (state == S_WRITE) && (ptr < DEPTH_L);
  assign ptr_nxt = ptr + 1'b1;
  assign nxt_ovf = (ptr_nxt >= DEPTH_L);

  imem_byte_serializer #(
    .WORD_W     (WORD_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (hs),
    .word      (in_data),
    .adv       (writing),
    .byte_out  (ser_byte),
    .last_lane (ser_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_ACCEPT;
            ptr        <= {1'b0, base_addr};
            word_count <= '0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            state  <= S_WRITE;
            last_q <= in_last;
          end
        end
        S_WRITE: begin
          if (!writing) begin
            state <= S_ERR;
          end else begin
            ptr <= ptr_nxt;
            if (ser_last) begin
              if (word_count != {CNT_W{1'b1}}) word_count <= word_count + 1'b1;
              if (last_q)       state <= S_DONE;
              else if (nxt_ovf) state <= S_ERR;
              else              state <= S_ACCEPT;
            end else if (nxt_ovf) begin
              state <= S_ERR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output byte/address hold their last written values between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold <= '0;
      data_hold <= '0;
    end else if (writing) begin
      addr_hold <= ptr[ADDR_W-1:0];
      data_hold <= ser_byte;
    end
  end

  assign in_ready  = (state == S_ACCEPT);
  assign mem_we    = writing;
  assign mem_addr  = writing ? ptr[ADDR_W-1:0] : addr_hold;
  assign mem_wdata = writing ? ser_byte : data_hold;
  assign cpu_hold  = (state != S_DONE);
  assign done      = (state == S_DONE);
  assign err_ovf   = (state == S_ERR);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: big-endian main instance plus a
// little-endian instance, each with a byte RAM model on its write port.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_le = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, cpu_hold, done, err_ovf;
  logic [7:0]  mem_addr, mem_wdata;
  logic [15:0] word_count;

  logic        in_ready_le, mem_we_le, cpu_hold_le, done_le, err_ovf_le;
  logic [7:0]  mem_addr_le, mem_wdata_le;
  logic [15:0] word_count_le;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [256];
  logic [7:0] ram_le [256];
  int wr_cnt = 0;
  int ready_in_write = 0;

  always #5 clk = ~clk;

  imem_stream_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err_ovf(err_ovf), .word_count(word_count)
  );

  imem_stream_loader #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .start(start_le), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready_le), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we_le), .mem_addr(mem_addr_le), .mem_wdata(mem_wdata_le),
    .cpu_hold(cpu_hold_le), .done(done_le), .err_ovf(err_ovf_le), .word_count(word_count_le)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt++;
      if (in_ready) ready_in_write++;
    end
    if (mem_we_le) ram_le[mem_addr_le] <= mem_wdata_le;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_word_timeout: in_ready=%0b required 1", in_ready);
    end
    checks++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(done || err_ovf) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (!(done || err_ovf)) begin
      errors++;
      $display("FAIL wait_end_timeout: done=%0b err_ovf=%0b required one set", done, err_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err_ovf, word_count} !==
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: rdy=%0b we=%0b addr=%h wd=%h hold=%0b done=%0b ovf=%0b wc=%0d required 0 0 00 00 1 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err_ovf, word_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready=%0b cpu_hold=%0b required 0 1", in_ready, cpu_hold);
    end
  endtask

  task automatic test_basic_be();
    int w0 = wr_cnt;
    pulse_start(8'h00);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_after_start: in_ready=%0b required 1", in_ready);
    end
    send_word(32'hE3A01005, 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'hE3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_write_timing: we=%0b addr=%h wd=%h rdy=%0b required 1 00 e3 0",
               mem_we, mem_addr, mem_wdata, in_ready);
    end
    send_word(32'hE2811001, 1'b0);
    send_word(32'hEAFFFFFE, 1'b1);
    wait_end(50);
    checks++;
    if (wr_cnt - w0 !== 12) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required 12", wr_cnt - w0);
    end
    checks++;
    if ({ram[0], ram[3], ram[4], ram[7], ram[8], ram[11]} !== {8'hE3, 8'h05, 8'hE2, 8'h01, 8'hEA, 8'hFE}) begin
      errors++;
      $display("FAIL basic_be_bytes: %h %h %h %h %h %h required e3 05 e2 01 ea fe",
               ram[0], ram[3], ram[4], ram[7], ram[8], ram[11]);
    end
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || err_ovf !== 1'b0 || word_count !== 16'd3) begin
      errors++;
      $display("FAIL basic_done: done=%0b hold=%0b ovf=%0b wc=%0d required 1 0 0 3", done, cpu_hold, err_ovf, word_count);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 8'd11 || mem_wdata !== 8'hFE) begin
      errors++;
      $display("FAIL hold_last_write: we=%0b addr=%h wd=%h required 0 0b fe", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_little_endian();
    int n = 0;
    base_addr = 8'h10;
    start_le = 1'b1;
    tick();
    start_le = 1'b0;
    in_data = 32'h11223344;
    in_last = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!done_le && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if ({ram_le[8'h10], ram_le[8'h11], ram_le[8'h12], ram_le[8'h13]} !== 32'h44332211) begin
      errors++;
      $display("FAIL le_bytes: %h %h %h %h required 44 33 22 11",
               ram_le[8'h10], ram_le[8'h11], ram_le[8'h12], ram_le[8'h13]);
    end
    checks++;
    if (done_le !== 1'b1 || cpu_hold_le !== 1'b0 || word_count_le !== 16'd1) begin
      errors++;
      $display("FAIL le_done: done=%0b hold=%0b wc=%0d required 1 0 1", done_le, cpu_hold_le, word_count_le);
    end
  endtask

  task automatic test_overflow();
    int w0;
    int rdy_seen = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    w0 = wr_cnt;
    pulse_start(8'd252);
    send_word(32'hA1B2C3D4, 1'b0);
    in_data = 32'h55667788;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (in_ready) rdy_seen++;
    end
    in_valid = 1'b0;
    checks++;
    if (wr_cnt - w0 !== 4 || rdy_seen !== 0) begin
      errors++;
      $display("FAIL ovf_no_second_word: writes=%0d ready_cycles=%0d required 4 0", wr_cnt - w0, rdy_seen);
    end
    checks++;
    if ({ram[252], ram[255]} !== {8'hA1, 8'hD4}) begin
      errors++;
      $display("FAIL ovf_first_word: %h %h required a1 d4", ram[252], ram[255]);
    end
    checks++;
    if (err_ovf !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 16'd1) begin
      errors++;
      $display("FAIL ovf_flags: ovf=%0b hold=%0b done=%0b wc=%0d required 1 1 0 1", err_ovf, cpu_hold, done, word_count);
    end
  endtask

  task automatic test_stream_random();
    logic [31:0] src [64];
    int i = 0;
    int guard = 0;
    int bad = 0;
    int n;
    logic hs;
    for (int k = 0; k < 64; k++) src[k] = $urandom;
    pulse_start(8'h00);
    while (i < 64 && guard < 5000) begin
      hs = 1'b0;
      if (in_ready) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = src[i];
        in_last  = (i == 63);
        hs = in_valid;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
      end
      tick();
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_end(50);
    for (int k = 0; k < 64; k++)
      if ({ram[4*k], ram[4*k+1], ram[4*k+2], ram[4*k+3]} !== src[k]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_image: mismatching words=%0d required 0", bad);
    end
    checks++;
    if (done !== 1'b1 || err_ovf !== 1'b0 || word_count !== 16'd64) begin
      errors++;
      $display("FAIL full_depth_done: done=%0b ovf=%0b wc=%0d required 1 0 64", done, err_ovf, word_count);
    end
    checks++;
    if (ready_in_write !== 0) begin
      errors++;
      $display("FAIL ready_in_write: cycles=%0d required 0", ready_in_write);
    end
    // valid held high: 8 words must take exactly 5 cycles each
    pulse_start(8'h40);
    in_valid = 1'b1;
    i = 0;
    n = 0;
    while (!done && n < 100) begin
      if (in_ready) begin
        in_data = 32'h01020304 + i;
        in_last = (i == 7);
        i++;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    checks++;
    if (n !== 40 || word_count !== 16'd8) begin
      errors++;
      $display("FAIL throughput: cycles=%0d wc=%0d required 40 8", n, word_count);
    end
  endtask

  task automatic test_reset_midload();
    int w0;
    pulse_start(8'h00);
    w0 = wr_cnt;
    for (int k = 0; k < 4; k++) send_word(32'hC0DE0000 + k, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err_ovf, word_count} !==
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL midload_reset: rdy=%0b we=%0b addr=%h wd=%h hold=%0b done=%0b ovf=%0b wc=%0d required 0 0 00 00 1 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err_ovf, word_count);
    end
    checks++;
    if (wr_cnt - w0 !== 18 || ram[16] !== 8'hDE || ram[17] !== 8'hAD) begin
      errors++;
      $display("FAIL partial_image: writes=%0d b16=%h b17=%h required 18 de ad", wr_cnt - w0, ram[16], ram[17]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: in_ready=%0b required 0", in_ready);
    end
    reset = 1'b0;
    pulse_start(8'h00);
    send_word(32'h0A0B0C0D, 1'b0);
    send_word(32'h1A1B1C1D, 1'b0);
    send_word(32'h2A2B2C2D, 1'b1);
    wait_end(50);
    checks++;
    if (done !== 1'b1 || word_count !== 16'd3 || ram[0] !== 8'h0A || ram[11] !== 8'h2D) begin
      errors++;
      $display("FAIL reload_after_reset: done=%0b wc=%0d b0=%h b11=%h required 1 3 0a 2d", done, word_count, ram[0], ram[11]);
    end
  endtask

  task automatic test_start_ignored();
    pulse_start(8'h20);
    send_word(32'h99887766, 1'b0);
    base_addr = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'h55443322, 1'b1);
    wait_end(50);
    checks++;
    if ({ram[8'h20], ram[8'h23], ram[8'h24], ram[8'h27]} !== 32'h99665522 || word_count !== 16'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_write: %h %h %h %h wc=%0d done=%0b required 99 66 55 22 2 1",
               ram[8'h20], ram[8'h23], ram[8'h24], ram[8'h27], word_count, done);
    end
    pulse_start(8'h00);
    checks++;
    if (done !== 1'b0 || word_count !== 16'd0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_done: done=%0b wc=%0d hold=%0b rdy=%0b required 0 0 1 1", done, word_count, cpu_hold, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_be();
    test_little_endian();
    test_overflow();
    test_stream_random();
    test_reset_midload();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
